// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for a 5-stage pipeline with a multi-cycle MUL/DIV unit in Execute.
// Adds load-use stalling, branch flushing, a MUL/DIV busy tracker and saturating stall/flush counters.
//
// state | meaning
// IDLE  | no multi-cycle op in flight; a MUL/DIV arriving here starts the hold
// BUSY  | MUL/DIV still occupying Execute; cnt counts remaining held cycles
module hazard_ctrl_mc #(
    parameter int REG_ADDR_W   = 5,
    parameter int MD_LATENCY   = 4,
    parameter int CNT_W        = 16,
    parameter bit X0_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  regWriteM,
    input  logic                  regWriteW,
    input  logic                  resultSrcE0,
    input  logic [1:0]            PCSrcE,
    input  logic                  mdOpE,
    input  logic                  ctrClear,
    output logic [1:0]            forwardAE,
    output logic [1:0]            forwardBE,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  flushD,
    output logic                  flushE,
    output logic                  flushM,
    output logic                  mdBusy,
    output logic [CNT_W-1:0]      stallCount,
    output logic [CNT_W-1:0]      flushCount
);

    localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = (MD_LATENCY > 1) ? CW'(MD_LATENCY - 2) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, BUSY} mdState_t;

    mdState_t state, nextState;
    logic [CW-1:0] cnt, nextCnt;
    logic lwStall, branch, mdStall;

    function automatic logic nz(input logic [REG_ADDR_W-1:0] r);
        return X0_HARDWIRED ? (r != '0) : 1'b1;
    endfunction

    function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] rs);
        if (regWriteM && rs == RdM && nz(rs))
            return 2'b10;
        else if (regWriteW && rs == RdW && nz(rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        forwardAE = fwdSel(Rs1E);
        forwardBE = fwdSel(Rs2E);
        lwStall   = resultSrcE0 && (Rs1D == RdE || Rs2D == RdE) && nz(RdE);
        branch    = (PCSrcE != 2'b00);
    end

    // A taken branch kills any MUL/DIV in Execute, so it always returns the tracker to IDLE.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        mdStall   = 1'b0;
        case (state)
            IDLE: begin
                if (mdOpE && !branch && MD_LATENCY > 1) begin
                    mdStall   = 1'b1;
                    nextState = BUSY;
                    nextCnt   = CNT_INIT;
                end
            end
            BUSY: begin
                if (branch) begin
                    nextState = IDLE;
                    nextCnt   = '0;
                end else if (cnt != '0) begin
                    mdStall = 1'b1;
                    nextCnt = cnt - 1'b1;
                end else begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
                nextCnt   = '0;
            end
        endcase
        if (!rst_n)
            mdStall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    always_comb begin
        stallF = lwStall || mdStall;
        stallD = lwStall || mdStall;
        stallE = mdStall;
        flushD = branch;
        flushE = (lwStall || branch) && !mdStall;
        flushM = mdStall;
        mdBusy = (state == BUSY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || ctrClear) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stallF && stallCount != CNT_MAX)
                stallCount <= stallCount + 1'b1;
            if ((flushD || flushE) && flushCount != CNT_MAX)
                flushCount <= flushCount + 1'b1;
        end
    end

endmodule
